// File: rtl/rf_pkg.sv
// Shared types and default sizing for the register file and its clear sequencer.
package rf_pkg;

  localparam int RF_WIDTH  = 16;
  localparam int RF_ADDR_W = 4;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  localparam int RF_DEPTH = depth_of(RF_ADDR_W);

  typedef enum logic {
    IDLE,
    CLEARING
  } rf_state_t;

endpackage

// File: rtl/rf_clear_seq.sv
// Bulk-clear sequencer: walks a counter over every register, one per cycle,
// and decides whether an incoming write may reach the storage array.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              write_en,
  output logic              busy,
  output logic              write_drop,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              write_ok
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  rf_state_t         state;
  logic [ADDR_W-1:0] count;

  // Clear wins over a same-cycle write; nothing is written while clearing.
  assign write_ok = (state == IDLE) && write_en && !clear;
  assign clr_we   = (state == CLEARING);
  assign clr_addr = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      busy       <= 1'b0;
      write_drop <= 1'b0;
    end else begin
      write_drop <= write_en && !write_ok;
      case (state)
        IDLE: begin
          if (clear) begin
            state <= CLEARING;
            count <= '0;
            busy  <= 1'b1;
          end
        end
        CLEARING: begin
          count <= count + ADDR_W'(1);
          if (count == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file feeding the ALU operands, with optional
// write-to-read bypass and a sequenced bulk clear.
module register_file
  import rf_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int ADDR_W = RF_ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              WriteEn,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic [ADDR_W-1:0] ReadAddrA,
  input  logic [ADDR_W-1:0] ReadAddrB,
  input  logic              Clear,
  output logic [WIDTH-1:0]  ReadDataA,
  output logic [WIDTH-1:0]  ReadDataB,
  output logic              Busy,
  output logic              WriteDrop
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [WIDTH-1:0]  regs [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              write_ok;

  rf_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .clear     (Clear),
    .write_en  (WriteEn),
    .busy      (Busy),
    .write_drop(WriteDrop),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .write_ok  (write_ok)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (clr_we) begin
      regs[clr_addr] <= '0;
    end else if (write_ok) begin
      regs[WriteAddr] <= WriteData;
    end
  end

  // Bypass only forwards a write that will actually land, so dropped writes never leak.
  always_comb begin
    ReadDataA = regs[ReadAddrA];
    ReadDataB = regs[ReadAddrB];
    if (BYPASS && write_ok && (ReadAddrA == WriteAddr)) begin
      ReadDataA = WriteData;
    end
    if (BYPASS && write_ok && (ReadAddrB == WriteAddr)) begin
      ReadDataB = WriteData;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: stimulus queues expected outputs, a
// negedge monitor pops and compares them against the DUT.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write_en = 1'b0;
  logic [3:0]  write_addr = '0;
  logic [15:0] write_data = '0;
  logic [3:0]  read_addr_a = '0;
  logic [3:0]  read_addr_b = '0;
  logic        clear = 1'b0;
  logic [15:0] read_data_a;
  logic [15:0] read_data_b;
  logic        busy;
  logic        write_drop;

  localparam int SEL_A  = 0;
  localparam int SEL_B  = 1;
  localparam int SEL_BUSY = 2;
  localparam int SEL_WD = 3;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] want;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  register_file #(
    .WIDTH (16),
    .ADDR_W(4),
    .BYPASS(1'b1)
  ) dut (
    .Clk      (clk),
    .Rst_n    (rst_n),
    .WriteEn  (write_en),
    .WriteAddr(write_addr),
    .WriteData(write_data),
    .ReadAddrA(read_addr_a),
    .ReadAddrB(read_addr_b),
    .Clear    (clear),
    .ReadDataA(read_data_a),
    .ReadDataB(read_data_b),
    .Busy     (busy),
    .WriteDrop(write_drop)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                               input logic [3:0] ra, input logic [3:0] rb, input logic clr);
    @(posedge clk);
    #1;
    write_en    = we;
    write_addr  = wa;
    write_data  = wd;
    read_addr_a = ra;
    read_addr_b = rb;
    clear       = clr;
  endtask

  task automatic idleRead(input logic [3:0] ra, input logic [3:0] rb);
    applyStimulus(1'b0, 4'd0, 16'h0000, ra, rb, 1'b0);
  endtask

  task automatic checkOutput(input string name, input int sel, input logic [15:0] want);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.want = want;
    sb.push_back(e);
  endtask

  // Monitor: everything queued during the current cycle is compared at the falling edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        SEL_A:    act = read_data_a;
        SEL_B:    act = read_data_b;
        SEL_BUSY: act = {15'd0, busy};
        default:  act = {15'd0, write_drop};
      endcase
      checks++;
      if (act !== e.want) begin
        failures++;
        $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", e.name, act, e.want);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state, checked while reset is still held.
    checkOutput("reset_busy", SEL_BUSY, 16'h0);
    checkOutput("reset_wdrop", SEL_WD, 16'h0);
    checkOutput("reset_a", SEL_A, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      idleRead(4'(i), 4'(15 - i));
      checkOutput("post_reset_a", SEL_A, 16'h0000);
      checkOutput("post_reset_b", SEL_B, 16'h0000);
    end
    checkOutput("post_reset_busy", SEL_BUSY, 16'h0);
    checkOutput("post_reset_wdrop", SEL_WD, 16'h0);

    // Basic writes and bypass.
    applyStimulus(1'b1, 4'd3, 16'hBEEF, 4'd3, 4'd0, 1'b0);
    checkOutput("bypass_r3", SEL_A, 16'hBEEF);
    checkOutput("r0_during_r3_write", SEL_B, 16'h0000);
    applyStimulus(1'b1, 4'd12, 16'h1234, 4'd3, 4'd12, 1'b0);
    checkOutput("stored_r3", SEL_A, 16'hBEEF);
    checkOutput("bypass_r12", SEL_B, 16'h1234);
    idleRead(4'd3, 4'd12);
    checkOutput("read_r3", SEL_A, 16'hBEEF);
    checkOutput("read_r12", SEL_B, 16'h1234);

    // Fill, then clear: exactly 16 busy cycles, partial clear visible.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 4'(i), 16'h1000 + 16'(i), 4'd0, 4'd0, 1'b0);
    end
    applyStimulus(1'b0, 4'd0, 16'h0000, 4'd0, 4'd15, 1'b1);
    checkOutput("busy_before_clear", SEL_BUSY, 16'h0);
    checkOutput("fill_r0", SEL_A, 16'h1000);
    checkOutput("fill_r15", SEL_B, 16'h100F);
    for (int c = 0; c < 16; c++) begin
      idleRead((c == 0) ? 4'd0 : 4'(c - 1), 4'(c));
      checkOutput("clear_busy", SEL_BUSY, 16'h1);
      checkOutput("clear_below", SEL_A, (c == 0) ? 16'h1000 : 16'h0000);
      checkOutput("clear_at_count", SEL_B, 16'h1000 + 16'(c));
    end
    idleRead(4'd0, 4'd15);
    checkOutput("busy_after_clear", SEL_BUSY, 16'h0);
    for (int i = 0; i < 8; i++) begin
      idleRead(4'(2 * i), 4'(2 * i + 1));
      checkOutput("cleared_even", SEL_A, 16'h0000);
      checkOutput("cleared_odd", SEL_B, 16'h0000);
    end

    // Write during clearing is dropped; a second clear is ignored.
    applyStimulus(1'b1, 4'd7, 16'h7777, 4'd0, 4'd0, 1'b0);
    applyStimulus(1'b0, 4'd0, 16'h0000, 4'd7, 4'd0, 1'b1);
    checkOutput("r7_before_clear", SEL_A, 16'h7777);
    for (int c = 0; c < 16; c++) begin
      applyStimulus(c == 2, 4'd7, 16'hAAAA, 4'd7, 4'd7, c == 8);
      checkOutput("clr2_busy", SEL_BUSY, 16'h1);
      checkOutput("clr2_r7", SEL_A, (c <= 7) ? 16'h7777 : 16'h0000);
      checkOutput("clr2_wdrop", SEL_WD, (c == 3) ? 16'h1 : 16'h0);
    end
    idleRead(4'd7, 4'd0);
    checkOutput("clr2_busy_done", SEL_BUSY, 16'h0);
    checkOutput("clr2_r7_final", SEL_A, 16'h0000);
    checkOutput("clr2_wdrop_final", SEL_WD, 16'h0);

    // Write and clear together in IDLE: clear wins, write dropped.
    applyStimulus(1'b1, 4'd9, 16'h9999, 4'd0, 4'd0, 1'b0);
    applyStimulus(1'b1, 4'd9, 16'h1111, 4'd0, 4'd0, 1'b1);
    checkOutput("coll_busy_pre", SEL_BUSY, 16'h0);
    checkOutput("coll_wdrop_pre", SEL_WD, 16'h0);
    for (int c = 0; c < 16; c++) begin
      idleRead(4'd9, 4'd9);
      checkOutput("coll_busy", SEL_BUSY, 16'h1);
      checkOutput("coll_r9", SEL_A, (c <= 9) ? 16'h9999 : 16'h0000);
      checkOutput("coll_wdrop", SEL_WD, (c == 0) ? 16'h1 : 16'h0);
    end
    idleRead(4'd9, 4'd0);
    checkOutput("coll_busy_done", SEL_BUSY, 16'h0);
    checkOutput("coll_r9_final", SEL_A, 16'h0000);

    // Asynchronous reset in the middle of a clear sequence.
    applyStimulus(1'b1, 4'd10, 16'hA5A5, 4'd0, 4'd0, 1'b0);
    applyStimulus(1'b1, 4'd14, 16'hEEEE, 4'd0, 4'd0, 1'b0);
    applyStimulus(1'b0, 4'd0, 16'h0000, 4'd10, 4'd14, 1'b1);
    for (int c = 0; c < 6; c++) begin
      idleRead(4'd10, 4'd14);
      checkOutput("rst_pre_busy", SEL_BUSY, 16'h1);
      checkOutput("rst_pre_r10", SEL_A, 16'hA5A5);
      checkOutput("rst_pre_r14", SEL_B, 16'hEEEE);
    end
    idleRead(4'd10, 4'd14);
    #1;
    rst_n = 1'b0;
    checkOutput("rst_mid_busy", SEL_BUSY, 16'h0);
    checkOutput("rst_mid_r10", SEL_A, 16'h0000);
    checkOutput("rst_mid_r14", SEL_B, 16'h0000);
    checkOutput("rst_mid_wdrop", SEL_WD, 16'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'd2, 16'h5555, 4'd2, 4'd10, 1'b0);
    checkOutput("post_rst_bypass_r2", SEL_A, 16'h5555);
    checkOutput("post_rst_r10", SEL_B, 16'h0000);
    checkOutput("post_rst_busy", SEL_BUSY, 16'h0);
    idleRead(4'd2, 4'd14);
    checkOutput("post_rst_r2", SEL_A, 16'h5555);
    checkOutput("post_rst_r14", SEL_B, 16'h0000);

    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 16-entry x 16-bit general-purpose register file at the write-back end of the CPU datapath.
- Consumes WriteData produced by the write-back select stage (ALU result vs memory read data) and supplies operands A and B to the ALU.
- Two combinational read ports and one synchronous write port, with optional write-to-read bypass.
- Sequenced bulk-clear engine zeroes all registers on command, one per cycle, and reports busy.

Parameters:
- WIDTH, 16, data width of each register and of all data ports.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers.
- BYPASS, 1, 1 = a read of the address being written this cycle returns WriteData; 0 = returns the stored value.

Ports:
- Clk  input  1  single clock, rising-edge.
- Rst_n  input  1  asynchronous, active-low reset.
- WriteEn  input  1  write request for this cycle.
- WriteAddr  input  ADDR_W  destination register.
- WriteData  input  WIDTH  write-back value from the write-back select stage.
- ReadAddrA  input  ADDR_W  operand A address.
- ReadAddrB  input  ADDR_W  operand B address.
- Clear  input  1  start bulk clear (level-sampled; one cycle is sufficient).
- ReadDataA  output  WIDTH  operand A, combinational.
- ReadDataB  output  WIDTH  operand B, combinational.
- Busy  output  1  registered; 1 while the clear sequence runs.
- WriteDrop  output  1  registered one-cycle pulse: a write was rejected the previous cycle.

Behaviour:
- Clocking and reset:
  - One clock, Clk. Reset is asynchronous and active-low on Rst_n.
  - While Rst_n=0: every register = 0, state = IDLE, clear counter = 0, Busy = 0, WriteDrop = 0.
  - Reset asserted mid-clear aborts the sequence immediately; all registers are zeroed by reset itself.
- States: IDLE, CLEARING.
- IDLE:
  - WriteEn=1 at a rising edge: Regs[WriteAddr] <= WriteData. Write latency is 1 cycle; the value is visible through the stored path on the next cycle.
  - Clear=1 at a rising edge: go to CLEARING with counter=0 and Busy<=1. Clear has priority: a WriteEn in the same cycle is rejected and WriteDrop=1 on the next cycle.
- CLEARING:
  - Each cycle: Regs[counter] <= 0 and counter <= counter+1.
  - When counter == DEPTH-1, that register is cleared, the block returns to IDLE and Busy<=0 on the same edge.
  - Total sequence is exactly DEPTH (16) cycles of Busy=1.
  - WriteEn=1 in CLEARING: write ignored, WriteDrop=1 on the next cycle.
  - Clear=1 in CLEARING: ignored; the sequence does not restart.
- Reads:
  - Purely combinational from the addresses and stored state; any number of same-address reads are allowed.
  - BYPASS=1, IDLE, WriteEn=1 and ReadAddrX == WriteAddr: ReadDataX = WriteData.
  - No bypass in CLEARING, because writes are dropped there.
  - During CLEARING, reads return current stored contents, partially cleared: registers below the counter read 0.
- Width rules: all data paths are exactly WIDTH bits, with no extension or truncation. The counter is ADDR_W bits and wraps naturally at the end of the sequence.
- No register is hardwired to zero; R0 is writable.

Decomposition:
- Shared package rf_pkg holds:
  - WIDTH and ADDR_W defaults (16 and 4).
  - The rf_state_t enum {IDLE, CLEARING}.
  - The DEPTH localparam derived from ADDR_W.
- One sub-module, rf_clear_seq: owns the state, counter, Busy and WriteDrop. It outputs clr_we/clr_addr and a write-accept gate to the storage array in register_file.

Test Plan:
- Reset then read all 16 addresses on both ports -> every read is 0x0000; Busy=0; WriteDrop=0.
- Write R3=0xBEEF and R12=0x1234 on consecutive cycles, then read A=3, B=12 -> 0xBEEF and 0x1234. With BYPASS=1, A=3 in the write cycle of R3 -> 0xBEEF in that same cycle.
- Fill R0..R15 with 0x1000+i, pulse Clear for 1 cycle -> Busy high exactly 16 cycles. Five cycles after entry, R0..R4 read 0 and R5 reads 0x1005. After exit all registers read 0.
- WriteEn R7=0xAAAA during CLEARING -> WriteDrop pulses 1 cycle later and R7 reads 0 after the sequence. WriteEn and Clear in the same cycle in IDLE -> write dropped, WriteDrop=1.
- Second Clear pulse at cycle 8 of CLEARING -> ignored; Busy still drops after a total of 16 cycles.
- Assert Rst_n=0 asynchronously, mid-cycle, during CLEARING at count 6 -> Busy=0 and all registers 0 immediately. After release, a write R2=0x5555 succeeds on the next edge.
